// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the select of a 16:1 bit mux.
// One owner at a time; grants end on done, request withdrawal or hold timeout.
//
// state | meaning
// IDLE  | no owner; arbitrate from ptr upward with wrap
// GRANT | sel/gnt owned, hold counter running
// GAP   | one dead cycle after release so the mux output can settle
module mux16_rr_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        valid,
    output logic        tout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [3:0]    ptr;
    logic [3:0]    winner;
    logic [3:0]    idx;
    logic          found;

    // First set request at or above ptr, wrapping through 15 back to 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 4'd0;
            gnt   <= 16'd0;
            valid <= 1'b0;
            tout  <= 1'b0;
            cnt   <= '0;
            ptr   <= 4'd0;
        end else begin
            tout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= winner;
                        gnt   <= 16'(1) << winner;
                        valid <= 1'b1;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // done/withdrawal win over a coinciding timeout, so tout stays low then.
                    if (done || !req[sel] || cnt == CNT_LAST) begin
                        gnt   <= 16'd0;
                        valid <= 1'b0;
                        ptr   <= sel + 4'd1;
                        state <= GAP;
                        tout  <= !done && req[sel];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares the 16:1 bit-select mux datapath between 16 requesters.
- Drives the 4-bit mux select and a one-hot grant vector.
- Holds a grant until the owner releases it, drops its request, or a hold timeout expires.
- Sits directly in front of the mux16to1 sel input; requester i owns mux input in[i] while granted.

Parameters:
TIMEOUT, 255, maximum cycles a grant is held before forced release; legal range 1..(2^TW - 1)
TW, 8, width of the hold counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  16  request vector; bit i = requester i wants the mux
done  input  1  current owner releases grant; sampled only in GRANT
sel  output  4  mux select = index of current/last owner (registered)
gnt  output  16  one-hot grant; all-zero when no owner (registered)
valid  output  1  high while a grant is active (registered)
tout  output  1  one-cycle pulse when a grant is force-released by timeout

Behaviour:
- Async reset (rst high, any time, including mid-grant):
  - state=IDLE; sel=0, gnt=0, valid=0, tout=0; hold counter=0; priority pointer ptr=0.
  - Outputs change immediately on rst assertion, not at the next edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, pick the first set bit searching upward from ptr with wrap (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
  - Next edge: sel=winner, gnt=1<<winner, valid=1, counter=0, state=GRANT.
  - Grant latency from request to gnt is 1 cycle.
  - If req==0, stay in IDLE; outputs unchanged (sel keeps its last value).
- GRANT, evaluated every edge in this priority order:
  1. done==1 -> normal release.
  2. req[sel]==0 -> normal release (owner withdrew).
  3. counter==TIMEOUT-1 -> forced release; tout=1 for exactly that next cycle.
  4. Otherwise counter+=1 and the grant holds.
- On any release:
  - gnt=0, valid=0; sel holds the old owner value.
  - ptr=(sel+1) mod 16, computed with 4-bit wrap, so 15 -> 0.
  - state=GAP.
  - If done and timeout coincide, treat as a normal release: tout stays 0.
- GAP: a mandatory single dead cycle so the mux output can settle/turn around; next edge state=IDLE unconditionally. tout returns to 0.
- Minimum release-to-next-grant: 2 cycles (GAP, then IDLE arbitration). Back-to-back grants to the same requester are therefore never merged.
- Fairness: after requester k is served, all other requesters asserting continuously are served before k again.
- Grant duration with no done and req held: exactly TIMEOUT cycles of valid=1.
- Changes to req of non-owners during GRANT are ignored.
- Invariants:
  - gnt is always either 0 or one-hot.
  - When valid=1, gnt==1<<sel.
  - valid==|gnt.
- Counter width TW; counter saturation is never reached because release happens at TIMEOUT-1.

Test Plan:
- Reset/idle: assert rst mid-simulation during GRANT with sel=5 -> sel=0, gnt=0, valid=0, tout=0 asynchronously; after release, req=0 for 10 cycles -> outputs stay 0.
- Single requester: req=16'h0010, done pulsed 3 cycles after grant -> gnt=16'h0010, sel=4, valid=1 one cycle after req; valid drops the edge after done; one GAP cycle, then re-grant to 4 (ptr=5, wraps around to it).
- Round-robin rotation: req=16'hFFFF held, done pulsed each grant cycle -> sel sequence 0,1,2,...,15,0; each grant separated by exactly 2 cycles of valid=0.
- Wrap priority: after serving 15, req=16'h8001 -> grant 0 next, then 15.
- Timeout: TIMEOUT=4, req=16'h0100 held, done=0 -> valid high exactly 4 cycles, tout pulses once on the release cycle, gnt=0 in GAP, then re-grant to 8.
- Withdraw and coincidence:
  - Owner 3 drops req[3] -> release next edge, ptr=4; req=16'h0018 then grants 4.
  - done asserted on the same cycle as the timeout -> tout stays 0.
